// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive frame sequencer.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_DONE   = 3'd5
    } rx_state_e;

    localparam int PRESC_8  = 8;
    localparam int PRESC_16 = 16;
    localparam int PRESC_32 = 32;

    // Check point sits just after the three majority samples around P/2.
    localparam int CHK_OFS = 2;
    localparam int END_OFS = 1;

endpackage

// File: rtl/uart_rx_fsm.sv
// UART RX frame sequencer: drives the bit counter and per-bit strobes, reports data_valid.
// Optional UART_RX_FRAME_ERR_EN adds parity_error / framing_error pulse outputs.
module uart_rx_fsm
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               RX_IN,
    input  logic               PAR_EN,
    input  logic [PRESC_W-1:0] Prescale,
    input  logic [4:0]         edge_count,
    input  logic [3:0]         bit_count,
    input  logic               strt_glitch,
    input  logic               par_err,
    input  logic               stp_err,
    output logic               counter_enable,
    output logic               dat_samp_en,
    output logic               deser_en,
    output logic               strt_chk_en,
    output logic               par_chk_en,
    output logic               stp_chk_en,
    output logic               data_valid,
    output logic               busy
`ifdef UART_RX_FRAME_ERR_EN
    ,
    output logic               parity_error,
    output logic               framing_error
`endif
);

    rx_state_e          state_q, state_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               par_en_q, par_en_d;
    logic               frame_err_q, frame_err_d;

    logic               presc_legal;
    logic               start_ok;
    logic [PRESC_W-1:0] edge_w;
    logic [PRESC_W-1:0] chk_pt;
    logic [PRESC_W-1:0] end_pt;
    logic               at_chk;
    logic               at_chk1;
    logic               at_end;
    logic               bit_last;

    assign presc_legal = (Prescale == PRESC_W'(PRESC_8))  ||
                         (Prescale == PRESC_W'(PRESC_16)) ||
                         (Prescale == PRESC_W'(PRESC_32));
    assign start_ok    = !RX_IN && presc_legal;

    // Timing points come from the latched ratio so mid-frame Prescale changes are harmless.
    assign edge_w   = PRESC_W'(edge_count);
    assign chk_pt   = (presc_q >> 1) + PRESC_W'(CHK_OFS);
    assign end_pt   = presc_q - PRESC_W'(END_OFS);
    assign at_chk   = (edge_w == chk_pt);
    assign at_chk1  = (edge_w == chk_pt + PRESC_W'(1));
    assign at_end   = (edge_w == end_pt);
    assign bit_last = (bit_count == 4'(DATA_WIDTH));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            presc_q     <= '0;
            par_en_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            par_en_q    <= par_en_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        presc_d        = presc_q;
        par_en_d       = par_en_q;
        frame_err_d    = frame_err_q;
        counter_enable = 1'b0;
        dat_samp_en    = 1'b0;
        deser_en       = 1'b0;
        strt_chk_en    = 1'b0;
        par_chk_en     = 1'b0;
        stp_chk_en     = 1'b0;
        data_valid     = 1'b0;
        busy           = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
        parity_error   = 1'b0;
        framing_error  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d  = ST_START;
                    presc_d  = Prescale;
                    par_en_d = PAR_EN;
                end
            end
            ST_START: begin
                counter_enable = 1'b1;
                dat_samp_en    = 1'b1;
                busy           = 1'b1;
                strt_chk_en    = at_chk;
                if (at_end) begin
                    if (strt_glitch) begin
                        state_d = ST_IDLE;
`ifdef UART_RX_FRAME_ERR_EN
                        framing_error = 1'b1;
`endif
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                counter_enable = 1'b1;
                dat_samp_en    = 1'b1;
                busy           = 1'b1;
                deser_en       = at_chk;
                if (at_end && bit_last) begin
                    state_d = par_en_q ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                counter_enable = 1'b1;
                dat_samp_en    = 1'b1;
                busy           = 1'b1;
                par_chk_en     = at_chk;
                if (at_end) begin
                    frame_err_d = frame_err_q | par_err;
                    state_d     = ST_STOP;
                end
            end
            ST_STOP: begin
                counter_enable = 1'b1;
                dat_samp_en    = 1'b1;
                busy           = 1'b1;
                stp_chk_en     = at_chk;
                // Leave mid stop bit so a start edge right after it is caught.
                if (at_chk1) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                busy        = 1'b1;
                data_valid  = !(frame_err_q | stp_err);
                frame_err_d = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
                parity_error  = frame_err_q;
                framing_error = stp_err;
`endif
                if (start_ok) begin
                    state_d  = ST_START;
                    presc_d  = Prescale;
                    par_en_d = PAR_EN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Scoreboard bench for uart_rx_fsm with a behavioural edge/bit counter model.
module tb_uart_rx_fsm;

    localparam int DW = 8;
    localparam int PW = 6;

    localparam int K_STRT  = 0;
    localparam int K_DESER = 1;
    localparam int K_PAR   = 2;
    localparam int K_STP   = 3;
    localparam int K_DONE  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          RX_IN;
    logic          PAR_EN;
    logic [PW-1:0] Prescale;
    logic [4:0]    edge_count;
    logic [3:0]    bit_count;
    logic          strt_glitch;
    logic          par_err;
    logic          stp_err;
    logic          counter_enable;
    logic          dat_samp_en;
    logic          deser_en;
    logic          strt_chk_en;
    logic          par_chk_en;
    logic          stp_chk_en;
    logic          data_valid;
    logic          busy;
`ifdef UART_RX_FRAME_ERR_EN
    logic          parity_error;
    logic          framing_error;
`endif

    typedef struct {
        int   kind;
        int   edge_v;
        int   bit_v;
        logic dv;
    } ev_t;

    ev_t exp_q[$];
    int  errors = 0;
    int  checks = 0;

    uart_rx_fsm #(.DATA_WIDTH(DW), .PRESC_W(PW)) dut (
        .clk            (clk),
        .rst            (rst),
        .RX_IN          (RX_IN),
        .PAR_EN         (PAR_EN),
        .Prescale       (Prescale),
        .edge_count     (edge_count),
        .bit_count      (bit_count),
        .strt_glitch    (strt_glitch),
        .par_err        (par_err),
        .stp_err        (stp_err),
        .counter_enable (counter_enable),
        .dat_samp_en    (dat_samp_en),
        .deser_en       (deser_en),
        .strt_chk_en    (strt_chk_en),
        .par_chk_en     (par_chk_en),
        .stp_chk_en     (stp_chk_en),
        .data_valid     (data_valid),
        .busy           (busy)
`ifdef UART_RX_FRAME_ERR_EN
        ,
        .parity_error   (parity_error),
        .framing_error  (framing_error)
`endif
    );

    always #5 clk = ~clk;

    // Edge/bit counter model: counts oversampling ticks while enabled, clears when not.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_count <= '0;
            bit_count  <= '0;
        end else if (!counter_enable) begin
            edge_count <= '0;
            bit_count  <= '0;
        end else if (int'(edge_count) == int'(Prescale) - 1) begin
            edge_count <= '0;
            bit_count  <= bit_count + 4'd1;
        end else begin
            edge_count <= edge_count + 5'd1;
        end
    end

    function automatic string kname(input int k);
        case (k)
            K_STRT:  return "strt_chk";
            K_DESER: return "deser";
            K_PAR:   return "par_chk";
            K_STP:   return "stp_chk";
            default: return "done";
        endcase
    endfunction

    // Scoreboard monitor: every strobe / DONE cycle pops and compares the next expected event.
    always @(negedge clk) begin : mon
        logic [4:0] fl;
        ev_t        e;
        if (rst) begin
            fl = {busy && !counter_enable, stp_chk_en, par_chk_en, deser_en, strt_chk_en};
            for (int k = 0; k < 5; k++) begin
                if (fl[k]) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_%s: got edge=%0d bit=%0d, required no event",
                                 kname(k), edge_count, bit_count);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.kind != k ||
                            (k != K_DONE && (e.edge_v != int'(edge_count) || e.bit_v != int'(bit_count))) ||
                            (k == K_DONE && data_valid !== e.dv)) begin
                            errors++;
                            $display("FAIL scoreboard: got %s edge=%0d bit=%0d dv=%0b, required %s edge=%0d bit=%0d dv=%0b",
                                     kname(k), edge_count, bit_count, data_valid,
                                     kname(e.kind), e.edge_v, e.bit_v, e.dv);
                        end
                    end
                end
            end
            checks++;
            if (data_valid && !(busy && !counter_enable)) begin
                errors++;
                $display("FAIL stray_data_valid: got data_valid=1 outside DONE, required 0");
            end
        end
    end

    task automatic push_frame(input int p, input bit pe, input bit perr, input bit serr);
        int  chk;
        ev_t e;
        chk = p / 2 + 2;
        e = '{K_STRT, chk, 0, 1'b0};
        exp_q.push_back(e);
        for (int b = 1; b <= DW; b++) begin
            e = '{K_DESER, chk, b, 1'b0};
            exp_q.push_back(e);
        end
        if (pe) begin
            e = '{K_PAR, chk, DW + 1, 1'b0};
            exp_q.push_back(e);
        end
        e = '{K_STP, chk, pe ? DW + 2 : DW + 1, 1'b0};
        exp_q.push_back(e);
        e = '{K_DONE, 0, 0, !((pe && perr) || serr)};
        exp_q.push_back(e);
    endtask

    task automatic send_start();
        @(negedge clk);
        RX_IN = 1'b0;
        @(negedge clk);
        RX_IN = 1'b1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d pending events after %0d cycles, required 0",
                     name, exp_q.size(), budget);
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0; RX_IN = 1'b1; PAR_EN = 1'b0; Prescale = 6'd8;
        strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
        #12;
        checks++;
        if ({counter_enable, dat_samp_en, deser_en, strt_chk_en, par_chk_en,
             stp_chk_en, data_valid, busy} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got %b, required 00000000",
                     {counter_enable, dat_samp_en, deser_en, strt_chk_en, par_chk_en,
                      stp_chk_en, data_valid, busy});
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        $display("test_reset: done");
    endtask

    task automatic test_frame(input string name, input int p, input bit pe,
                              input bit perr, input bit serr);
        Prescale = PW'(p); PAR_EN = pe; par_err = perr; stp_err = serr;
        push_frame(p, pe, perr, serr);
        send_start();
        wait_drain(name, 20 * p);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: got busy=%b, required 0", name, busy);
        end
        repeat (3) @(negedge clk);
        par_err = 1'b0; stp_err = 1'b0; PAR_EN = 1'b0;
        $display("%s: P=%0d par_en=%0b par_err=%0b stp_err=%0b done", name, p, pe, perr, serr);
    endtask

    task automatic test_glitch();
        int  last_edge;
        int  busy_cycles;
        bit  seen_busy;
        ev_t e;
        Prescale = 6'd16; strt_glitch = 1'b1;
        e = '{K_STRT, 10, 0, 1'b0};
        exp_q.push_back(e);
        last_edge = -1; busy_cycles = 0; seen_busy = 1'b0;
        @(negedge clk);
        RX_IN = 1'b0;
        for (int n = 1; n < 100; n++) begin
            @(negedge clk);
            if (n == 3) RX_IN = 1'b1;
            if (busy) begin
                seen_busy = 1'b1;
                busy_cycles++;
                last_edge = int'(edge_count);
            end else if (seen_busy) begin
                break;
            end
        end
        checks++;
        if (last_edge != 15 || busy_cycles != 16) begin
            errors++;
            $display("FAIL glitch_abort: got last_edge=%0d busy_cycles=%0d, required 15 and 16",
                     last_edge, busy_cycles);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL glitch_idle: got pending=%0d busy=%b, required 0 and 0", exp_q.size(), busy);
        end
        exp_q.delete();
        strt_glitch = 1'b0;
        $display("test_glitch: done");
    endtask

    task automatic test_back_to_back();
        bit found;
        Prescale = 6'd8; PAR_EN = 1'b0;
        push_frame(8, 1'b0, 1'b0, 1'b0);
        push_frame(8, 1'b0, 1'b0, 1'b0);
        send_start();
        found = 1'b0;
        for (int n = 0; n < 200 && !found; n++) begin
            @(negedge clk);
            if (busy && !counter_enable) begin
                found = 1'b1;
                RX_IN = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if (!found || !(busy && counter_enable && edge_count == 5'd0 && bit_count == 4'd0)) begin
            errors++;
            $display("FAIL b2b_restart: got found=%0b busy=%b cen=%b edge=%0d bit=%0d, required 1 1 1 0 0",
                     found, busy, counter_enable, edge_count, bit_count);
        end
        RX_IN = 1'b1;
        wait_drain("b2b", 400);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: got busy=%b, required 0", busy);
        end
        repeat (3) @(negedge clk);
        $display("test_back_to_back: done");
    endtask

    task automatic test_reset_mid_and_bad_presc();
        bit in_data;
        bit bad;
        Prescale = 6'd16; PAR_EN = 1'b0;
        push_frame(16, 1'b0, 1'b0, 1'b0);
        send_start();
        in_data = 1'b0;
        for (int n = 0; n < 200 && !in_data; n++) begin
            @(negedge clk);
            if (bit_count == 4'd3) in_data = 1'b1;
        end
        checks++;
        if (!in_data || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_reach_data: got reached=%0b busy=%b, required 1 1", in_data, busy);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({counter_enable, dat_samp_en, deser_en, strt_chk_en, par_chk_en,
             stp_chk_en, data_valid, busy} !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: got %b, required 00000000",
                     {counter_enable, dat_samp_en, deser_en, strt_chk_en, par_chk_en,
                      stp_chk_en, data_valid, busy});
        end
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        Prescale = 6'd12;
        RX_IN = 1'b0;
        bad = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (busy || counter_enable) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL bad_prescale: got FSM left IDLE with Prescale=12, required stay IDLE");
        end
        RX_IN = 1'b1;
        Prescale = 6'd8;
        repeat (3) @(negedge clk);
        $display("test_reset_mid_and_bad_presc: done");
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_frame("test_p8_nopar", 8, 1'b0, 1'b0, 1'b0);
        test_frame("test_p16_par_bad", 16, 1'b1, 1'b1, 1'b0);
        test_frame("test_p16_par_good", 16, 1'b1, 1'b0, 1'b0);
        test_frame("test_p32_stop_bad", 32, 1'b0, 1'b0, 1'b1);
        test_glitch();
        test_back_to_back();
        test_reset_mid_and_bad_presc();
        test_frame("test_p8_after_reset", 8, 1'b0, 1'b0, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
